// File: rtl/bist_pkg.sv
// Shared types and widths for the SRAM March-test BIST response path.
package bist_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } analyzer_state_e;

  // One failure-log record: failing address and the bits that differed.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] syndrome;
  } log_entry_t;

  // One in-flight read waiting for its SRAM data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_data;
  } req_entry_t;

endpackage

// File: rtl/bist_fail_fifo.sv
// Failure log: first-word-fall-through FIFO of log entries.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous flush (pointers only)
//   push/din : write an entry (accepted when not full, or when popping)
//   pop      : retire the head entry (ignored when empty)
//   full, empty, head : status and head-of-queue entry
module bist_fail_fifo
  import bist_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  log_entry_t din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output log_entry_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  log_entry_t  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_wr;
  logic        w_rd;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd  = pop && !empty;
  // A pop frees the slot, so a simultaneous push is accepted even when full.
  assign w_wr  = push && (!full || w_rd);
  assign head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= din;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/march_response_analyzer.sv
// March-test response analyzer: aligns SRAM read data with expected data
// across the read latency, and records pass/fail, a saturating fail count
// and a FIFO log of failing address/syndrome pairs.
//   start, test_end          : run control pulses
//   addr, we, exp_data       : generator request stream (reads are we==0)
//   rd_data                  : SRAM data, valid RD_LATENCY cycles after request
//   busy, done               : RUN/DRAIN and DONE status
//   fail, fail_count         : sticky verdict and saturating mismatch count
//   log_valid/addr/syndrome  : head of the failure log; log_pop retires it
//   log_overflow             : sticky, a failure was dropped on a full log
module march_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned LOG_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              test_end,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  fail_count,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_syndrome,
  input  logic              log_pop,
  output logic              log_overflow
);

  analyzer_state_e         r_state;
  logic                    r_busy;
  logic                    r_done;
  logic [2:0]              r_drain_cnt;
  req_entry_t              r_dl [RD_LATENCY];
  logic [RD_LATENCY-1:0]   r_dl_valid;
  logic                    r_cmp_valid;
  log_entry_t              r_cmp_entry;
  logic                    r_fail;
  logic [CNT_W-1:0]        r_fail_count;
  logic                    r_overflow;

  logic                    w_req;
  logic [DATA_W-1:0]       w_syndrome;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  log_entry_t              w_head;

  // start pre-empts capture so a flushed pipeline stays empty.
  assign w_req      = (r_state == RUN) && !we && !start;
  assign w_syndrome = rd_data ^ r_dl[RD_LATENCY-1].exp_data;
  assign w_pop      = log_pop && !w_empty;

  // Run-control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_drain_cnt <= '0;
    end else if (start) begin
      r_state <= RUN;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (test_end) begin
            r_state     <= DRAIN;
            r_drain_cnt <= '0;
          end
        end
        DRAIN: begin
          // Extra cycle covers the registered compare stage.
          if (r_drain_cnt == 3'(RD_LATENCY)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 3'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Alignment delay line, registered comparator and result accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dl_valid   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_dl[i] <= '0;
      r_cmp_valid  <= 1'b0;
      r_cmp_entry  <= '0;
      r_fail       <= 1'b0;
      r_fail_count <= '0;
      r_overflow   <= 1'b0;
    end else if (start) begin
      r_dl_valid   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_dl[i] <= '0;
      r_cmp_valid  <= 1'b0;
      r_cmp_entry  <= '0;
      r_fail       <= 1'b0;
      r_fail_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_dl_valid[0] <= w_req;
      r_dl[0]       <= '{addr: addr, exp_data: exp_data};
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl[i]       <= r_dl[i-1];
      end
      r_cmp_valid <= r_dl_valid[RD_LATENCY-1] && (w_syndrome != '0);
      r_cmp_entry <= '{addr: r_dl[RD_LATENCY-1].addr, syndrome: w_syndrome};
      if (r_cmp_valid) begin
        r_fail <= 1'b1;
        if (r_fail_count != '1) r_fail_count <= r_fail_count + CNT_W'(1);
        if (w_full && !w_pop) r_overflow <= 1'b1;
      end
    end
  end

  bist_fail_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (r_cmp_valid && !start),
    .din   (r_cmp_entry),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign busy         = r_busy;
  assign done         = r_done;
  assign fail         = r_fail;
  assign fail_count   = r_fail_count;
  assign log_valid    = !w_empty;
  assign log_addr     = w_head.addr;
  assign log_syndrome = w_head.syndrome;
  assign log_overflow = r_overflow;

endmodule

// File: tb/tb_march_response_analyzer.sv
// Directed bench for march_response_analyzer: one instance at read latency 1,
// one at read latency 3, both with a 4-entry failure log.
module tb_march_response_analyzer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Latency-1 instance
  logic       start1 = 0, te1 = 0, we1 = 1, pop1 = 0;
  logic [7:0] addr1 = 0;
  logic [3:0] exp1 = 0, rd1 = 0, pend1 = 0;
  logic       busy1, done1, fail1, lv1, ovf1;
  logic [15:0] cnt1;
  logic [7:0] laddr1;
  logic [3:0] lsyn1;

  // Latency-3 instance
  logic       start3 = 0, te3 = 0, we3 = 1, pop3 = 0;
  logic [7:0] addr3 = 0;
  logic [3:0] exp3 = 0, rd3 = 0;
  logic       busy3, done3, fail3, lv3, ovf3;
  logic [15:0] cnt3;
  logic [7:0] laddr3;
  logic [3:0] lsyn3;

  int n_checks = 0;
  int n_fail   = 0;

  march_response_analyzer #(.RD_LATENCY(1), .LOG_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .test_end(te1), .addr(addr1), .we(we1),
    .exp_data(exp1), .rd_data(rd1), .busy(busy1), .done(done1), .fail(fail1),
    .fail_count(cnt1), .log_valid(lv1), .log_addr(laddr1), .log_syndrome(lsyn1),
    .log_pop(pop1), .log_overflow(ovf1));

  march_response_analyzer #(.RD_LATENCY(3), .LOG_DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .test_end(te3), .addr(addr3), .we(we3),
    .exp_data(exp3), .rd_data(rd3), .busy(busy3), .done(done3), .fail(fail3),
    .fail_count(cnt3), .log_valid(lv3), .log_addr(laddr3), .log_syndrome(lsyn3),
    .log_pop(pop3), .log_overflow(ovf3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One latency-1 cycle: present a request; rd data d appears on the next cycle.
  task automatic cyc1(input logic w, input logic [7:0] a, input logic [3:0] e, input logic [3:0] d);
    we1 = w; addr1 = a; exp1 = e; rd1 = pend1;
    tick();
    pend1 = d;
  endtask

  task automatic start_dut1();
    start1 = 1; tick(); start1 = 0;
  endtask

  task automatic pop_dut1();
    pop1 = 1; cyc1(1'b1, 8'h00, 4'h0, 4'h0); pop1 = 0;
  endtask

  // Last request carries test_end; done expected two edges later.
  task automatic end_dut1();
    te1 = 1; cyc1(1'b1, 8'h00, 4'h0, 4'h0); te1 = 0;
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    check("drain_busy", busy1, 1);
    check("drain_done", done1, 0);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_fail", fail1, 0);
    check("rst_cnt", cnt1, 0);
    check("rst_lv", lv1, 0);
    check("rst_laddr", laddr1, 0);
    check("rst_lsyn", lsyn1, 0);
    check("rst_ovf", ovf1, 0);
    @(negedge clk); rst = 0;
    tick();

    // Clean run: write sweep then read sweep with matching data
    start_dut1();
    check("start_busy", busy1, 1);
    for (int a = 0; a < 256; a++) cyc1(1'b1, 8'(a), 4'(a), 4'h0);
    for (int a = 0; a < 255; a++) cyc1(1'b0, 8'(a), 4'(a), 4'(a));
    te1 = 1; cyc1(1'b0, 8'hFF, 4'hF, 4'hF); te1 = 0;
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    check("clean_busy_drain", busy1, 1);
    check("clean_done_early", done1, 0);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    check("clean_done", done1, 1);
    check("clean_busy", busy1, 0);
    check("clean_fail", fail1, 0);
    check("clean_cnt", cnt1, 0);
    check("clean_lv", lv1, 0);

    // Single fault: bit 2 stuck at 0 at 5A
    start_dut1();
    cyc1(1'b0, 8'h5A, 4'hF, 4'hB);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    check("sf_fail_not_yet", fail1, 0);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    check("sf_fail", fail1, 1);
    check("sf_cnt", cnt1, 1);
    check("sf_lv", lv1, 1);
    check("sf_laddr", laddr1, 8'h5A);
    check("sf_lsyn", lsyn1, 4'h4);
    end_dut1();
    check("sf_done", done1, 1);
    check("sf_fail_hold", fail1, 1);

    // Log overflow: six mismatches at 1..6
    start_dut1();
    check("restart_fail_clr", fail1, 0);
    for (int a = 1; a <= 6; a++) cyc1(1'b0, 8'(a), 4'h0, 4'h1);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    check("ovf_cnt", cnt1, 6);
    check("ovf_flag", ovf1, 1);
    check("ovf_head", laddr1, 8'h01);
    check("ovf_head_syn", lsyn1, 4'h1);
    for (int k = 2; k <= 4; k++) begin
      pop_dut1();
      check("ovf_pop_addr", laddr1, 32'(k));
      check("ovf_pop_lv", lv1, 1);
    end
    pop_dut1();
    check("ovf_empty", lv1, 0);
    pop_dut1();
    check("ovf_empty_pop", lv1, 0);
    check("ovf_cnt_hold", cnt1, 6);
    end_dut1();

    // Full log with simultaneous push and pop
    start_dut1();
    for (int a = 8'h21; a <= 8'h24; a++) cyc1(1'b0, 8'(a), 4'h3, 4'h0);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    check("fpp_head", laddr1, 8'h21);
    check("fpp_ovf_pre", ovf1, 0);
    cyc1(1'b0, 8'h30, 4'h3, 4'h1);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    pop1 = 1; cyc1(1'b1, 8'h00, 4'h0, 4'h0); pop1 = 0;
    check("fpp_ovf", ovf1, 0);
    check("fpp_cnt", cnt1, 5);
    check("fpp_head2", laddr1, 8'h22);
    pop_dut1(); pop_dut1(); pop_dut1();
    check("fpp_new_entry", laddr1, 8'h30);
    check("fpp_new_syn", lsyn1, 4'h2);
    pop_dut1();
    check("fpp_empty", lv1, 0);
    end_dut1();

    // Reset mid-run after two failures
    start_dut1();
    cyc1(1'b0, 8'h40, 4'h5, 4'h4);
    cyc1(1'b0, 8'h41, 4'h5, 4'h7);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    check("mid_cnt", cnt1, 2);
    @(negedge clk); rst = 1; #1;
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_fail", fail1, 0);
    check("mid_rst_cnt", cnt1, 0);
    check("mid_rst_lv", lv1, 0);
    check("mid_rst_laddr", laddr1, 0);
    @(negedge clk); rst = 0;
    tick();
    start_dut1();
    for (int a = 0; a < 16; a++) cyc1(1'b0, 8'(a), 4'(a + 3), 4'(a + 3));
    end_dut1();
    check("after_rst_done", done1, 1);
    check("after_rst_pass", fail1, 0);

    // Latency 3 alignment: correct data only on the third cycle
    start3 = 1; tick(); start3 = 0;
    we3 = 0; addr3 = 8'h10; exp3 = 4'hA; rd3 = 4'h5; tick();
    we3 = 1; addr3 = 8'h77; exp3 = 4'h1; te3 = 1; rd3 = 4'h7; tick();
    te3 = 0; rd3 = 4'hC; tick();
    rd3 = 4'hA; tick();
    rd3 = 4'h3; tick();
    check("l3_busy", busy3, 1);
    check("l3_done_early", done3, 0);
    rd3 = 4'h9; tick();
    check("l3_done", done3, 1);
    check("l3_fail", fail3, 0);
    check("l3_cnt", cnt3, 0);

    // Latency 3 mismatch: logged with syndrome from the aligned cycle
    start3 = 1; tick(); start3 = 0;
    we3 = 0; addr3 = 8'h20; exp3 = 4'h5; rd3 = 4'h5; tick();
    we3 = 1; rd3 = 4'h5; tick();
    rd3 = 4'h5; tick();
    rd3 = 4'h4; tick();
    rd3 = 4'h5;
    check("l3_fail_not_yet", fail3, 0);
    tick();
    check("l3_mis_fail", fail3, 1);
    check("l3_mis_addr", laddr3, 8'h20);
    check("l3_mis_syn", lsyn3, 4'h1);

    // fail_count saturation
    start_dut1();
    for (int i = 0; i < 65540; i++) cyc1(1'b0, 8'(i), 4'h0, 4'hF);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    cyc1(1'b1, 8'h00, 4'h0, 4'h0);
    check("sat_cnt", cnt1, 16'hFFFF);
    check("sat_fail", fail1, 1);
    check("sat_ovf", ovf1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/march_response_analyzer.md
# march_response_analyzer

Output-side checker for the 256x4 SRAM March-test BIST. It consumes the pattern generator's address, write-enable and expected-data stream together with the SRAM read data. Read data is aligned against the expected value across the SRAM read latency, and every mismatch is recorded. The block reports a sticky pass/fail verdict, a saturating fail count and a small log of failing addresses and bit syndromes, which the controller drains after the test.

## Interface
- RD_LATENCY, 1: cycles from a read request (addr/we sampled) to valid rd_data; legal 1..4.
- LOG_DEPTH, 4: failure-log entries; power of two, 2..16.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; clears results and enters RUN.
- test_end  in  1  one-cycle pulse from the generator after its last March element.
- addr  in  8  SRAM address driven this cycle.
- we  in  1  1 = write cycle (ignored), 0 = read cycle (checked).
- exp_data  in  4  expected read value for this cycle's read.
- rd_data  in  4  SRAM read data, valid RD_LATENCY cycles after the request.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- fail  out  1  sticky; set on the first mismatch.
- fail_count  out  16  number of mismatches, saturates at 16'hFFFF.
- log_valid  out  1  failure log not empty.
- log_addr  out  8  address of the oldest logged failure.
- log_syndrome  out  4  rd_data XOR exp_data of the oldest logged failure.
- log_pop  in  1  pops the oldest entry when log_valid is high.
- log_overflow  out  1  sticky; a failure was dropped because the log was full.

## Operation
- States are IDLE, RUN, DRAIN and DONE. Reset enters IDLE.
- IDLE -> RUN on start. RUN -> DRAIN on test_end. DRAIN -> DONE after RD_LATENCY cycles. DONE -> RUN on start.
- start in any state clears fail, fail_count, log_overflow, the log and the alignment pipeline, then enters RUN.
- In RUN only, a read request is `we`==0. On each read request, {addr, exp_data} enters a RD_LATENCY-deep delay line with a valid bit. A read request on the test_end cycle is still captured.
- When the delayed valid bit is high, compare rd_data against the delayed exp_data. If they differ, a mismatch occurs:
  - set fail;
  - increment fail_count, saturating;
  - push {delayed addr, syndrome} into the log if it is not full; otherwise set log_overflow.
- DRAIN retires in-flight compares and accepts no new requests. No new entries enter the delay line in IDLE, DRAIN or DONE.
- The log is a FIFO with first-word fall-through. log_addr and log_syndrome are held at the head entry while log_valid is high. Pop while empty is ignored.
- A push and a pop in the same cycle are both honoured, including when the log is full; no overflow occurs in that case.
- Pass verdict: done && !fail.

## Timing
- Reset values: busy 0, done 0, fail 0, fail_count 0, log_valid 0, log_addr 0, log_syndrome 0, log_overflow 0. The delay line is cleared.
- Latency from a read request at edge t:
  - the compare occurs at edge t+RD_LATENCY;
  - fail, fail_count and the log update are visible after edge t+RD_LATENCY+1 (registered);
  - log_valid rises in the same cycle as fail.
- busy drops and done rises exactly RD_LATENCY+1 cycles after the test_end edge.
- Reset asserted mid-test forces the reset values immediately; no partial results are retained.
- If start and test_end are high together, start wins.

## Structure
- Shared package bist_pkg holds:
  - ADDR_W=8, DATA_W=4;
  - the analyzer state enum {IDLE, RUN, DRAIN, DONE};
  - the log-entry struct {addr, syndrome}.
- Sub-module bist_fail_fifo implements the LOG_DEPTH failure log: push, pop, full, empty, and a head-of-queue output.
- The top level holds the FSM, the delay line, the comparator and the counter.

## Test plan
- **Clean run.** RD_LATENCY=1; full 256-address write/read sweep with rd_data = exp_data -> done high with fail=0, fail_count=0 and log_valid=0.
- **Single fault.** rd_data bit 2 stuck at 0 at address 8'h5A while exp_data=4'hF -> fail=1, fail_count=1, log_addr=8'h5A, log_syndrome=4'h4.
- **Latency alignment.** RD_LATENCY=3; stimulus is a read of addr 8'h10, exp 4'hA, with rd_data=4'hA three cycles later and garbage on all other cycles -> no fail. done rises 4 cycles after test_end.
- **Log overflow.** LOG_DEPTH=4; 6 mismatches at addresses 1..6 -> fail_count=6, log_overflow=1. Popping 4 times yields addresses 1, 2, 3, 4, then log_valid=0.
- **Full-log push/pop.** With the log full, pop in the same cycle as a new mismatch -> entry accepted, log_overflow stays 0.
- **Reset and restart.** Assert rst during RUN after 2 failures -> all outputs return to 0 at once. A subsequent start plus a clean sweep -> pass. fail_count saturation is checked by forcing 65,540 mismatches -> fail_count=16'hFFFF.
